// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program-counter register and instruction-fetch sequencer
//
// Holds the architectural PC, fetches the instruction at pc over a req/ack
// handshake, holds it until the core advances, then loads next_pc verbatim.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   next_pc   [PC_W]      next PC from the next-PC logic (sampled on advance)
//   advance               core consumed instr; load next_pc and refetch
//   halt                  stop after the current instruction (priority over advance)
//   imem_req              read request (high only in REQ)
//   imem_addr [PC_W]      read address, always equal to pc
//   imem_ack              memory returns imem_rdata this cycle
//   imem_rdata[INSTR_W]   instruction word
//   pc        [PC_W]      current PC
//   instr     [INSTR_W]   held instruction
//   instr_valid           instr belongs to the current pc
//   halted                block is in HALT
//   retired   [8]         accepted advances, wraps 255->0
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               advance,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic [7:0]         retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [7:0]         retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    retired_d     = retired_q;
    unique case (state_q)
      // One quiet cycle after reset release before the first request.
      IDLE: state_d = REQ;
      // advance/halt are deliberately ignored while a fetch is outstanding.
      REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALT;
        end else if (advance) begin
          // Dropping valid on the same edge as the pc load means instr is
          // never flagged valid against a pc it was not fetched from.
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          retired_d     = retired_q + 8'd1;
          state_d       = REQ;
        end
      end
      // Sticky until reset; everything frozen.
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Decoded from state so an async reset drops the request immediately.
  assign imem_req    = (state_q == REQ);
  assign halted      = (state_q == HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  next_pc;
  logic        advance;
  logic        halt;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [7:0]  retired;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .advance    (advance),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        adv, hlt, ack;
    logic [7:0]  np;
    logic [15:0] rd;
    logic        e_req, e_valid, e_halted;
    logic [7:0]  e_pc, e_ret;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},     {31'd0, imem_req},    32'd0);
    check({tag, " valid"},   {31'd0, instr_valid}, 32'd0);
    check({tag, " retired"}, {24'd0, retired},     32'd0);
    check({tag, " pc"},      {24'd0, pc},          32'h00);
    check({tag, " halted"},  {31'd0, halted},      32'd0);
  endtask

  initial begin
    int adv_cnt;
    int cyc;

    //        adv hlt ack np     rd        req val hlt pc     ret    instr
    vecs[0]  = '{0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 8'd0, 16'h0000};
    vecs[1]  = '{0, 0, 1, 8'h00, 16'hA5A5, 1, 0, 0, 8'h00, 8'd0, 16'h0000};
    vecs[2]  = '{1, 0, 0, 8'h01, 16'h0000, 0, 1, 0, 8'h00, 8'd0, 16'hA5A5};
    vecs[3]  = '{0, 0, 1, 8'h00, 16'h1111, 1, 0, 0, 8'h01, 8'd1, 16'h0000};
    vecs[4]  = '{1, 0, 0, 8'h02, 16'h0000, 0, 1, 0, 8'h01, 8'd1, 16'h1111};
    vecs[5]  = '{0, 0, 1, 8'h00, 16'h2222, 1, 0, 0, 8'h02, 8'd2, 16'h0000};
    vecs[6]  = '{1, 0, 0, 8'h03, 16'h0000, 0, 1, 0, 8'h02, 8'd2, 16'h2222};
    vecs[7]  = '{0, 0, 1, 8'h00, 16'h3333, 1, 0, 0, 8'h03, 8'd3, 16'h0000};
    vecs[8]  = '{1, 0, 0, 8'h04, 16'h0000, 0, 1, 0, 8'h03, 8'd3, 16'h3333};
    // three wait cycles; advance/halt during REQ must be ignored
    vecs[9]  = '{1, 0, 0, 8'hAA, 16'h0000, 1, 0, 0, 8'h04, 8'd4, 16'h0000};
    vecs[10] = '{1, 1, 0, 8'hAB, 16'hDEAD, 1, 0, 0, 8'h04, 8'd4, 16'h0000};
    vecs[11] = '{0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h04, 8'd4, 16'h0000};
    vecs[12] = '{0, 0, 1, 8'h00, 16'hBEEF, 1, 0, 0, 8'h04, 8'd4, 16'h0000};
    // jump to 4C; stray ack in HOLD ignored
    vecs[13] = '{1, 0, 1, 8'h4C, 16'h6666, 0, 1, 0, 8'h04, 8'd4, 16'hBEEF};
    vecs[14] = '{0, 0, 1, 8'h00, 16'h4C4C, 1, 0, 0, 8'h4C, 8'd5, 16'h0000};
    // halt and advance together: halt wins
    vecs[15] = '{1, 1, 0, 8'h99, 16'h0000, 0, 1, 0, 8'h4C, 8'd5, 16'h4C4C};
    vecs[16] = '{1, 0, 1, 8'h77, 16'h1234, 0, 1, 1, 8'h4C, 8'd5, 16'h4C4C};
    vecs[17] = '{0, 0, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h4C, 8'd5, 16'h4C4C};

    rst_n = 1'b0; advance = 1'b0; halt = 1'b0; next_pc = 8'h00;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      advance = vecs[i].adv; halt = vecs[i].hlt; imem_ack = vecs[i].ack;
      next_pc = vecs[i].np;  imem_rdata = vecs[i].rd;
      check($sformatf("v%0d req", i),    {31'd0, imem_req},    {31'd0, vecs[i].e_req});
      check($sformatf("v%0d addr", i),   {24'd0, imem_addr},   {24'd0, vecs[i].e_pc});
      check($sformatf("v%0d pc", i),     {24'd0, pc},          {24'd0, vecs[i].e_pc});
      check($sformatf("v%0d valid", i),  {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d halted", i), {31'd0, halted},      {31'd0, vecs[i].e_halted});
      check($sformatf("v%0d retired", i),{24'd0, retired},     {24'd0, vecs[i].e_ret});
      if (vecs[i].e_valid)
        check($sformatf("v%0d instr", i), {16'd0, instr}, {16'd0, vecs[i].e_instr});
      tick();
    end

    // HALT is sticky: no requests, nothing moves, for 20 cycles
    advance = 1'b1; imem_ack = 1'b1; halt = 1'b0; next_pc = 8'h11;
    for (int i = 0; i < 20; i++) begin
      check("halt req", {31'd0, imem_req}, 32'd0);
      check("halt halted", {31'd0, halted}, 32'd1);
      check("halt pc", {24'd0, pc}, 32'h4C);
      check("halt valid", {31'd0, instr_valid}, 32'd1);
      check("halt instr", {16'd0, instr}, 32'h4C4C);
      tick();
    end

    // only reset leaves HALT
    rst_n = 1'b0;
    #1;
    check_reset_outputs("halt exit");
    tick();
    rst_n = 1'b1;

    // 256 zero-wait advances: retired wraps to 0, pc wraps via pc+1
    adv_cnt = 0; cyc = 0;
    while (adv_cnt < 256 && cyc < 3000) begin
      imem_ack = imem_req; imem_rdata = {8'h5A, imem_addr};
      next_pc = pc + 8'd1; advance = 1'b1; halt = 1'b0;
      check("wrap retired", {24'd0, retired}, adv_cnt % 256);
      if (instr_valid) begin
        check("wrap instr", {16'd0, instr}, {16'd0, 8'h5A, pc});
        adv_cnt++;
      end
      tick();
      cyc++;
    end
    check("wrap done in budget", {31'd0, (adv_cnt == 256)}, 32'd1);
    check("wrap retired final", {24'd0, retired}, 32'd0);
    check("wrap pc final", {24'd0, pc}, 32'h00);
    check("wrap halted", {31'd0, halted}, 32'd0);
    check("wrap req", {31'd0, imem_req}, 32'd1);

    // two more advances, then park in REQ without an ack
    cyc = 0;
    while (adv_cnt < 258 && cyc < 100) begin
      imem_ack = imem_req; imem_rdata = {8'h5A, imem_addr};
      next_pc = pc + 8'd1; advance = 1'b1;
      if (instr_valid) adv_cnt++;
      tick();
      cyc++;
    end
    imem_ack = 1'b0; advance = 1'b0;
    check("pre-reset retired", {24'd0, retired}, 32'd2);
    tick();
    check("pre-reset req", {31'd0, imem_req}, 32'd1);
    check("pre-reset pc", {24'd0, pc}, 32'h02);

    // async reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    check("rel c1 req", {31'd0, imem_req}, 32'd0);
    tick();
    check("rel c2 req", {31'd0, imem_req}, 32'd1);
    check("rel c2 addr", {24'd0, imem_addr}, 32'h00);
    tick();
    check("rel c3 instr", {16'd0, instr}, 32'hA5A5);
    check("rel c3 valid", {31'd0, instr_valid}, 32'd1);
    check("rel c3 retired", {24'd0, retired}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter register and instruction-fetch sequencer that closes the loop around the next-PC logic. It holds the architectural PC and presents it as `pc` to the next-PC logic. It fetches the instruction at `pc` from instruction memory over a req/ack handshake and holds it valid until the core advances. On advance it loads the next-PC value (sequential, branch or jump target) and starts the next fetch.

## Interface
- `PC_W`, 8, PC and instruction-memory address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 8'h00, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed
- `next_pc`  in  PC_W  next PC computed by the next-PC logic from `pc`
- `advance`  in  1  core has consumed `instr`; load `next_pc` and fetch again
- `halt`  in  1  stop fetching after the current instruction is held
- `imem_req`  out  1  instruction-memory read request
- `imem_addr`  out  PC_W  read address; equals `pc`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  instruction word
- `pc`  out  PC_W  current PC, fed to the next-PC logic
- `instr`  out  INSTR_W  held instruction
- `instr_valid`  out  1  `instr` is valid for the current `pc`
- `halted`  out  1  block is in HALT
- `retired`  out  8  count of accepted advances, wraps 255→0

## Operation
- States: IDLE, REQ, HOLD, HALT. `imem_req` = (state==REQ), combinational; `halted` = (state==HALT).
- Reset (async, `rst_n`=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, retired=0. Therefore imem_req=0 and halted=0.
- IDLE: unconditionally → REQ on the next edge. This gives exactly one quiet cycle after reset release.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - If `imem_ack`=1: capture instr←imem_rdata, set instr_valid←1, and go → HOLD.
  - Otherwise stay in REQ with the request held.
  - `advance` and `halt` are ignored in REQ.
- HOLD: instr_valid=1.
  - If `halt`=1: go → HALT. `halt` has priority over `advance`. pc and instr are unchanged and instr_valid stays 1.
  - Else if `advance`=1: pc←next_pc, instr_valid←0, retired←retired+1 (mod 256), and go → REQ.
  - Else stay in HOLD.
- HALT: sticky. No requests, and all registers frozen. Exit is by reset only.
- `imem_ack` outside REQ is ignored. `imem_rdata` is sampled only when req&&ack.
- `next_pc` is sampled only on an advance edge. Its value at any other time is don't-care.
- PC arithmetic is done upstream. This block loads `next_pc` verbatim, with no width change.

## Timing
- imem_addr and pc are stable for the whole of REQ. pc changes only on an advance edge in HOLD.
- Zero-wait memory (ack in the first REQ cycle): REQ 1 cycle, then HOLD. The minimum instruction period is 2 cycles, when `advance` is asserted in the first HOLD cycle.
- N-wait memory: REQ lasts N+1 cycles. instr_valid rises on the edge after the ack cycle.
- instr_valid falls on the edge that loads the new pc. There is never a cycle with instr_valid=1 and instr from a stale pc.
- retired increments on the same edge as the pc load.
- Reset asserted mid-REQ: imem_req drops immediately, which is asynchronous and therefore combinational via state. The memory must tolerate an abandoned request.
- Reset release: first request is asserted in the 2nd cycle after release.

## Test plan
- Reset and first fetch: hold rst_n=0, then release. Memory returns 16'hA5A5 for addr 8'h00 with zero wait.
  - Cycle 1 after release: imem_req=0.
  - Cycle 2: imem_req=1, addr=00.
  - Cycle 3: instr=A5A5, instr_valid=1, retired=0.
- Sequential stream: next_pc=pc+1, advance held at 1, zero-wait memory, 4 instructions.
  - pc steps 00,01,02,03, each on alternate cycles.
  - retired=4 after the 4th advance.
  - instr_valid toggles 1/0.
- Wait states plus redirect: memory has 3 wait cycles, and next_pc=8'h4C (jump target) at the advance.
  - imem_addr=pc held stable for 4 REQ cycles.
  - After the advance, imem_addr=4C.
  - advance pulses during REQ change nothing.
- Halt priority: in HOLD, assert halt=1 and advance=1 in the same cycle.
  - halted=1 and pc unchanged; instr and instr_valid=1 held.
  - imem_req stays 0 for 20 cycles.
  - Only rst_n returns the block to IDLE.
- Counter wrap: 256 advances → retired=0, with no other effect.
- Async reset mid-wait: in REQ with no ack, pulse rst_n low between clock edges.
  - imem_req, instr_valid and retired go to 0 immediately, and pc=RESET_PC.
  - The reset-release sequence then repeats.
